// File: rtl/half_adder_pkg.sv
// Shared constants for the half-adder slice: default and maximum lane counts.
package half_adder_pkg;

    localparam int unsigned HA_DEFAULT_WIDTH = 1;
    localparam int unsigned HA_MAX_WIDTH     = 64;

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle for half_adder; master drives operands, slave returns results.
interface half_adder_if
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;

    modport master (
        output a, b, in_valid,
        input  sum, carry, sum_q, carry_q, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output sum, carry, sum_q, carry_q, out_valid
    );

endinterface

// File: rtl/ha_cell.sv
// Single-bit combinational half adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with combinational results and an optional
// in_valid-qualified register stage.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = HA_DEFAULT_WIDTH,
    parameter bit          REG_OUT = 1'b1
) (
    input logic          clk,
    input logic          rst,
    half_adder_if.slave  bus
);

    if (WIDTH == 0 || WIDTH > HA_MAX_WIDTH) begin : g_bad_width
        $error("half_adder: WIDTH %0d outside 1..%0d", WIDTH, HA_MAX_WIDTH);
    end

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] carry_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_cell u_cell (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .sum   (sum_w[i]),
            .carry (carry_w[i])
        );
    end

    assign bus.sum   = sum_w;
    assign bus.carry = carry_w;

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_d, sum_q;
        logic [WIDTH-1:0] carry_d, carry_q;
        logic             valid_q;

        // Results hold when no operand is offered.
        always_comb begin
            sum_d   = sum_q;
            carry_d = carry_q;
            if (bus.in_valid) begin
                sum_d   = sum_w;
                carry_d = carry_w;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= '0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                valid_q <= bus.in_valid;
            end
        end

        assign bus.sum_q     = sum_q;
        assign bus.carry_q   = carry_q;
        assign bus.out_valid = valid_q;
    end else begin : g_noreg
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign bus.sum_q     = '0;
        assign bus.carry_q   = '0;
        assign bus.out_valid = 1'b0;
    end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: directed truth-table/reset cases plus random traffic checked
// against a lane-arithmetic model, across WIDTH 1/4/8 and an unregistered variant.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_sq;
    logic [7:0] exp_cq;
    logic       exp_v;

    always #5 clk = ~clk;

    half_adder_if #(.WIDTH(1)) bus1 ();
    half_adder_if #(.WIDTH(4)) bus4 ();
    half_adder_if #(.WIDTH(8)) bus8 ();
    half_adder_if #(.WIDTH(8)) busz ();

    assign bus1.a = a[0:0];
    assign bus1.b = b[0:0];
    assign bus1.in_valid = in_valid;
    assign bus4.a = a[3:0];
    assign bus4.b = b[3:0];
    assign bus4.in_valid = in_valid;
    assign bus8.a = a;
    assign bus8.b = b;
    assign bus8.in_valid = in_valid;
    assign busz.a = a;
    assign busz.b = b;
    assign busz.in_valid = in_valid;

    half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    half_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    half_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_dutz (.clk(clk), .rst(rst), .bus(busz));

    // Each lane is a 2-bit sum of two bits: {carry,sum} = x[i] + y[i].
    function automatic logic [15:0] lanes(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        logic [7:0] c;
        int t;
        for (int i = 0; i < 8; i++) begin
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = t >= 2;
        end
        return {c, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] r;
        logic [7:0]  s;
        logic [7:0]  c;
        r = lanes(a, b);
        s = r[7:0];
        c = r[15:8];
        check({tag, ":sum1"},  64'(bus1.sum),       64'(s[0]));
        check({tag, ":car1"},  64'(bus1.carry),     64'(c[0]));
        check({tag, ":sq1"},   64'(bus1.sum_q),     64'(exp_sq[0]));
        check({tag, ":cq1"},   64'(bus1.carry_q),   64'(exp_cq[0]));
        check({tag, ":ov1"},   64'(bus1.out_valid), 64'(exp_v));
        check({tag, ":sum4"},  64'(bus4.sum),       64'(s[3:0]));
        check({tag, ":car4"},  64'(bus4.carry),     64'(c[3:0]));
        check({tag, ":sq4"},   64'(bus4.sum_q),     64'(exp_sq[3:0]));
        check({tag, ":cq4"},   64'(bus4.carry_q),   64'(exp_cq[3:0]));
        check({tag, ":ov4"},   64'(bus4.out_valid), 64'(exp_v));
        check({tag, ":sum8"},  64'(bus8.sum),       64'(s));
        check({tag, ":car8"},  64'(bus8.carry),     64'(c));
        check({tag, ":sq8"},   64'(bus8.sum_q),     64'(exp_sq));
        check({tag, ":cq8"},   64'(bus8.carry_q),   64'(exp_cq));
        check({tag, ":ov8"},   64'(bus8.out_valid), 64'(exp_v));
        check({tag, ":sumz"},  64'(busz.sum),       64'(s));
        check({tag, ":carz"},  64'(busz.carry),     64'(c));
        check({tag, ":regz"},  64'({busz.sum_q, busz.carry_q, busz.out_valid}), 64'(0));
    endtask

    // Advance one rising edge, update the expected registered view, sample 1 ns later.
    task automatic step();
        logic [15:0] r;
        @(posedge clk);
        if (rst) begin
            exp_sq = '0;
            exp_cq = '0;
            exp_v  = 1'b0;
        end else begin
            if (in_valid) begin
                r      = lanes(a, b);
                exp_sq = r[7:0];
                exp_cq = r[15:8];
            end
            exp_v = in_valid;
        end
        #1;
    endtask

    logic [1:0] tt_ab [4];
    logic [1:0] tt_sc [4];

    initial begin
        tt_ab = '{2'b00, 2'b10, 2'b01, 2'b11};
        tt_sc = '{2'b00, 2'b10, 2'b10, 2'b01};

        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        exp_sq = '0;
        exp_cq = '0;
        exp_v  = 1'b0;

        // Reset state; combinational path must work while held in reset.
        #2;
        a = 8'hA5;
        b = 8'h3C;
        in_valid = 1'b1;
        #1;
        check_all("reset");
        step();
        check_all("reset_hold");
        rst = 1'b0;
        in_valid = 1'b0;

        // Single-lane truth table, 100 ns between changes, no capture.
        for (int k = 0; k < 4; k++) begin
            a = {7'h00, tt_ab[k][1]};
            b = {7'h00, tt_ab[k][0]};
            repeat (10) step();
            check("truth_table", 64'({bus1.sum, bus1.carry}), 64'(tt_sc[k]));
            check_all("truth_table_all");
        end

        // 1+1 captured one edge later.
        a = 8'h01;
        b = 8'h01;
        in_valid = 1'b1;
        step();
        check("cap11", 64'({bus1.sum_q, bus1.carry_q, bus1.out_valid}), 64'(3'b011));
        check_all("cap11_all");

        // Hold with in_valid low; out_valid drops after one cycle.
        a = 8'h01;
        b = 8'h00;
        step();
        a = 8'h01;
        b = 8'h01;
        in_valid = 1'b0;
        step();
        check("hold", 64'({bus1.sum_q, bus1.carry_q, bus1.out_valid}), 64'(3'b100));
        check_all("hold_all");

        // Eight-lane pattern.
        a = 8'hF0;
        b = 8'hCC;
        in_valid = 1'b1;
        #1;
        check("w8_comb", 64'({bus8.carry, bus8.sum}), 64'(16'hC03C));
        step();
        check("w8_reg", 64'({bus8.carry_q, bus8.sum_q, bus8.out_valid}), 64'({16'hC03C, 1'b1}));
        check_all("w8_all");

        // Exhaustive four-lane sweep with random upper bits and random capture.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a = {4'($urandom), 4'(x)};
                b = {4'($urandom), 4'(y)};
                in_valid = 1'($urandom);
                #1;
                for (int i = 0; i < 4; i++) begin
                    check("sweep_lane", 64'({bus4.carry[i], bus4.sum[i]}),
                          64'(int'(a[i]) + int'(b[i])));
                end
                step();
                check_all("sweep");
            end
        end

        // Random traffic, mostly back-to-back valid.
        repeat (300) begin
            a = 8'($urandom);
            b = 8'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            step();
            check_all("random");
        end

        // Asynchronous reset between edges while results are valid.
        a = 8'h5A;
        b = 8'hFF;
        in_valid = 1'b1;
        step();
        check_all("pre_rst");
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        exp_sq = '0;
        exp_cq = '0;
        exp_v  = 1'b0;
        #1;
        check_all("async_rst");
        a = 8'h3B;
        b = 8'hC6;
        #1;
        check_all("rst_comb");
        in_valid = 1'b1;
        step();
        check_all("rst_edge");
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check_all("post_rst_idle");
        a = 8'h77;
        b = 8'h0F;
        in_valid = 1'b1;
        step();
        check_all("post_rst_cap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
